arp_lookup_responder: RTL

- Network-side endpoint for the ARP lookup request/reply channel pair.
- Accepts 32-bit IP lookup requests and answers each with one 56-bit reply (MAC plus hit flag).
- Answers come from the local address, set over the set-IP/set-MAC channels, and from a small sequentially scanned ARP table.
- The table is filled through an update channel; used standalone or as a behavioural stand-in for the HLS ARP server in user-side test builds.

---
 rtl/arp_lookup_responder.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/arp_lookup_responder.sv
// rtl/arp_lookup_responder.sv - ARP lookup responder with local address and scanned ARP table
module arp_lookup_responder #(
  parameter int N_ENTRIES = 8,
  parameter int IDX_BITS  = $clog2(N_ENTRIES)
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        s_arp_lookup_request_valid,
  output logic        s_arp_lookup_request_ready,
  input  logic [31:0] s_arp_lookup_request_data,
  output logic        m_arp_lookup_reply_valid,
  input  logic        m_arp_lookup_reply_ready,
  output logic [55:0] m_arp_lookup_reply_data,
  input  logic        s_set_ip_addr_valid,
  output logic        s_set_ip_addr_ready,
  input  logic [31:0] s_set_ip_addr_data,
  input  logic        s_set_mac_addr_valid,
  output logic        s_set_mac_addr_ready,
  input  logic [47:0] s_set_mac_addr_data,
  input  logic        s_arp_update_valid,
  output logic        s_arp_update_ready,
  input  logic [79:0] s_arp_update_data,
  output logic [31:0] m_hit_cnt,
  output logic [31:0] m_miss_cnt
);

  typedef enum logic [2:0] {IDLE, L_SCAN, U_SCAN, U_WRITE, REPLY} state_t;

  state_t                state;
  logic                  running;
  logic [IDX_BITS-1:0]   idx;
  logic [IDX_BITS-1:0]   target;
  logic [IDX_BITS-1:0]   rr_ptr;
  logic [31:0]           key_ip;
  logic [47:0]           key_mac;
  logic [N_ENTRIES-1:0]  ent_valid;
  logic [31:0]           ent_ip  [N_ENTRIES];
  logic [47:0]           ent_mac [N_ENTRIES];
  logic [31:0]           local_ip;
  logic [47:0]           local_mac;
  logic                  local_ip_valid;
  logic                  local_mac_valid;
  logic                  entry_hit;
  logic                  last_entry;
  logic                  local_hit;

  assign entry_hit  = ent_valid[idx] && (ent_ip[idx] == key_ip);
  assign last_entry = (idx == IDX_BITS'(N_ENTRIES - 1));
  assign local_hit  = local_ip_valid && local_mac_valid && (s_arp_lookup_request_data == local_ip);

  // Updates win over lookups when both are offered in the same idle cycle.
  assign s_set_ip_addr_ready        = running;
  assign s_set_mac_addr_ready       = running;
  assign s_arp_update_ready         = running && (state == IDLE);
  assign s_arp_lookup_request_ready = running && (state == IDLE) && !s_arp_update_valid;

  // Holds all ready outputs low until the first clock after reset release.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) running <= 1'b0;
    else          running <= 1'b1;
  end

  // Local address registers, loaded on their own channels at any time.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      local_ip        <= '0;
      local_mac       <= '0;
      local_ip_valid  <= 1'b0;
      local_mac_valid <= 1'b0;
    end else begin
      if (s_set_ip_addr_valid && s_set_ip_addr_ready) begin
        local_ip       <= s_set_ip_addr_data;
        local_ip_valid <= 1'b1;
      end
      if (s_set_mac_addr_valid && s_set_mac_addr_ready) begin
        local_mac       <= s_set_mac_addr_data;
        local_mac_valid <= 1'b1;
      end
    end
  end

  // Table payload; entry validity lives in the FSM block so reset clears it.
  always_ff @(posedge aclk) begin
    if (state == U_WRITE) begin
      ent_ip[target]  <= key_ip;
      ent_mac[target] <= key_mac;
    end
  end

  // Main FSM: one table entry examined per cycle for both lookups and updates.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state                    <= IDLE;
      idx                      <= '0;
      target                   <= '0;
      rr_ptr                   <= '0;
      ent_valid                <= '0;
      key_ip                   <= '0;
      key_mac                  <= '0;
      m_arp_lookup_reply_valid <= 1'b0;
      m_arp_lookup_reply_data  <= '0;
      m_hit_cnt                <= '0;
      m_miss_cnt               <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (s_arp_update_valid && s_arp_update_ready) begin
            key_ip  <= s_arp_update_data[31:0];
            key_mac <= s_arp_update_data[79:32];
            idx     <= '0;
            state   <= U_SCAN;
          end else if (s_arp_lookup_request_valid && s_arp_lookup_request_ready) begin
            key_ip <= s_arp_lookup_request_data;
            idx    <= '0;
            if (local_hit) begin
              m_arp_lookup_reply_data  <= {7'd0, 1'b1, local_mac};
              m_arp_lookup_reply_valid <= 1'b1;
              state                    <= REPLY;
            end else begin
              state <= L_SCAN;
            end
          end
        end
        L_SCAN: begin
          if (entry_hit) begin
            m_arp_lookup_reply_data  <= {7'd0, 1'b1, ent_mac[idx]};
            m_arp_lookup_reply_valid <= 1'b1;
            state                    <= REPLY;
          end else if (last_entry) begin
            m_arp_lookup_reply_data  <= '0;
            m_arp_lookup_reply_valid <= 1'b1;
            state                    <= REPLY;
          end else begin
            idx <= idx + IDX_BITS'(1);
          end
        end
        U_SCAN: begin
          if (entry_hit) begin
            target <= idx;
            state  <= U_WRITE;
          end else if (last_entry) begin
            target <= rr_ptr;
            rr_ptr <= rr_ptr + IDX_BITS'(1);
            state  <= U_WRITE;
          end else begin
            idx <= idx + IDX_BITS'(1);
          end
        end
        U_WRITE: begin
          ent_valid[target] <= 1'b1;
          state             <= IDLE;
        end
        REPLY: begin
          if (m_arp_lookup_reply_ready) begin
            m_arp_lookup_reply_valid <= 1'b0;
            if (m_arp_lookup_reply_data[48]) m_hit_cnt  <= m_hit_cnt + 32'd1;
            else                             m_miss_cnt <= m_miss_cnt + 32'd1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
